// File: rtl/start_sequencer.sv
// Timed-run sequencer launched on a rising edge of the start detector's level.
// Drives a seconds countdown, a progress bar and the detector's hold-enable.
module start_sequencer #(
  parameter int TICK_COUNT   = 100_000_000,
  parameter int RUN_SECONDS  = 10,
  parameter int DONE_SECONDS = 3
) (
  input  logic        Master_Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Abort,
  output logic        task_active,
  output logic        running,
  output logic        done,
  output logic [3:0]  seconds_left,
  output logic [15:0] led
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUNNING, ST_DONE} state_t;

  localparam logic [26:0] TICK_LAST = 27'(TICK_COUNT - 1);
  localparam logic [3:0]  RUN_S     = 4'(RUN_SECONDS);
  localparam logic [3:0]  DONE_S    = 4'(DONE_SECONDS);

  state_t      state_reg;
  state_t      state_next;
  logic [26:0] tick_cnt_reg;
  logic [3:0]  done_cnt_reg;
  logic        start_q;
  logic        start_rise;
  logic        tick;
  logic [3:0]  elapsed_next;
  logic [15:0] bar_next;

  assign start_rise   = Start & ~start_q;
  assign tick         = (state_reg != ST_IDLE) && (tick_cnt_reg == TICK_LAST);
  // Elapsed seconds after the decrement this tick is about to apply.
  assign elapsed_next = RUN_S - (seconds_left - 4'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bar
      assign bar_next[gi] = (5'(gi) < {1'b0, elapsed_next});
    end
  endgenerate

  always_ff @(posedge Master_Clock) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_rise) state_next = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (Abort) state_next = ST_IDLE;
        else if (tick && seconds_left == 4'd1) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (Abort) state_next = ST_IDLE;
        else if (tick && done_cnt_reg == 4'd1) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    task_active = (state_reg == ST_IDLE);
    running     = (state_reg == ST_RUNNING);
    done        = (state_reg == ST_DONE);
  end

  // Tick counter restarts on every state entry so each run and DONE phase is whole seconds.
  always_ff @(posedge Master_Clock) begin
    if (Reset || state_reg == ST_IDLE || state_next != state_reg || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 27'd1;
    end
  end

  always_ff @(posedge Master_Clock) begin
    if (Reset) begin
      start_q      <= 1'b1;
      seconds_left <= 4'd0;
      led          <= 16'h0000;
      done_cnt_reg <= 4'd0;
    end else begin
      start_q <= Start;
      case (state_reg)
        ST_IDLE: begin
          if (start_rise) begin
            seconds_left <= RUN_S;
            led          <= 16'h0000;
          end
        end
        ST_RUNNING: begin
          if (Abort) begin
            seconds_left <= 4'd0;
            led          <= 16'h0000;
          end else if (tick) begin
            if (seconds_left == 4'd1) begin
              seconds_left <= 4'd0;
              led          <= 16'hFFFF;
              done_cnt_reg <= DONE_S;
            end else begin
              seconds_left <= seconds_left - 4'd1;
              led          <= bar_next;
            end
          end
        end
        ST_DONE: begin
          if (Abort) begin
            seconds_left <= 4'd0;
            led          <= 16'h0000;
          end else if (tick) begin
            if (done_cnt_reg == 4'd1) led <= 16'h0000;
            else done_cnt_reg <= done_cnt_reg - 4'd1;
          end
        end
        default: begin
          seconds_left <= 4'd0;
          led          <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: doc/start_sequencer.md
# start_sequencer

Downstream consumer of the subtask B switch-hold start detector. It watches the detector's `Start` level and launches a fixed-length timed run on its rising edge. During the run it drives a seconds countdown for the seven-segment display and a progress bar on the LEDs, then shows a done state. It also drives `task_active` back to the detector: the detector may only accumulate hold time while this block is idle.

## Interface
Parameters:
- `TICK_COUNT`, default 100_000_000: `Master_Clock` cycles per one-second tick (1 s at 100 MHz); legal range 2..2^27.
- `RUN_SECONDS`, default 10: run length in ticks; legal range 1..15.
- `DONE_SECONDS`, default 3: ticks spent in DONE before returning to IDLE; legal range 1..15.

Ports:
- `Master_Clock` in 1: single system clock; all logic on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Start` in 1: level from the start detector; synchronous to `Master_Clock`.
- `Abort` in 1: single-cycle pulse from a debounced pushbutton.
- `task_active` out 1: high only in IDLE; enables the detector's hold timer.
- `running` out 1: high in RUNNING.
- `done` out 1: high in DONE.
- `seconds_left` out 4: remaining run seconds, for the 7-seg decoder.
- `led` out 16: progress bar.

## Operation
- States: IDLE, RUNNING, DONE. Reset state is IDLE.
- Reset values:
  - `task_active`=1, `running`=0, `done`=0, `seconds_left`=0, `led`=16'h0000.
  - Tick counter = 0.
  - `start_q` (registered copy of `Start`) = 1. Setting it to 1 means a `Start` already high out of reset does not trigger a run.
- Edge detect: `start_rise` = `Start` & ~`start_q`. `start_q` updates every cycle in every state.
- Tick counter:
  - 27-bit counter; cleared on every state entry.
  - Increments in RUNNING and DONE. At `TICK_COUNT`-1 it wraps to 0 and asserts the internal one-cycle `tick`.
  - Holds 0 in IDLE.
- IDLE:
  - `start_rise` -> RUNNING, `seconds_left` loaded with `RUN_SECONDS`, `led`=0.
  - `Abort` in IDLE is ignored.
- RUNNING:
  - On `tick`, `seconds_left` decrements by 1.
  - `led[i]`=1 for i < (`RUN_SECONDS` − `seconds_left`), computed from the post-update value. All other bits are 0.
  - When a `tick` takes `seconds_left` from 1 to 0 -> DONE, `led`=16'hFFFF.
  - `Abort` -> IDLE, `seconds_left`=0, `led`=0.
  - `Start` is don't-care.
- DONE:
  - `seconds_left` holds 0 and `led` holds 16'hFFFF.
  - After `DONE_SECONDS` ticks (a 4-bit done counter loaded on entry), return to IDLE with `led`=0.
  - `Abort` -> IDLE immediately.
- Priority in RUNNING/DONE: `Reset` > `Abort` > `tick`. `Abort` coinciding with the final tick goes to IDLE, not DONE.
- Arithmetic:
  - `seconds_left` never underflows; it is only decremented while ≥1.
  - The elapsed count fits in 4 bits.
  - `led` bits at index ≥ `RUN_SECONDS` stay 0 while RUNNING.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start latency:
  - Let `Start` be first sampled high at edge N, with `start_q`=0.
  - After edge N: `running`=1, `task_active`=0, `seconds_left`=`RUN_SECONDS`.
- First decrement occurs after edge N+`TICK_COUNT`. Subsequent decrements follow every `TICK_COUNT` cycles.
- DONE entry coincides with the `RUN_SECONDS`-th tick. IDLE re-entry follows `DONE_SECONDS`×`TICK_COUNT` cycles later.
- `Abort` takes effect at the edge where it is sampled high; outputs update after that edge.
- `task_active` falls one cycle after `start_rise`. The detector then clears its timer and drops `Start`.
- A new run needs a fresh `Start` rise, and the detector only asserts `Start` after a full re-hold once `task_active` returns high.
- `Reset` mid-run:
  - Next edge forces the full reset state, including `start_q`=1.
  - A still-high `Start` must fall and rise again before a new run.

## Test plan
Bench parameters: `TICK_COUNT`=4, `RUN_SECONDS`=3, `DONE_SECONDS`=2.

1. Reset, then raise `Start` at cycle 10 -> after that edge `running`=1, `task_active`=0, `seconds_left`=3, `led`=0. `seconds_left` is then 2/1/0 with `led`=0001/0003/FFFF after edges 14/18/22. `done`=1 from edge 22. IDLE with `task_active`=1 and `led`=0 after edge 30.
2. Hold `Start`=1 through `Reset` release -> stays IDLE with `running`=0. Drop `Start` for 1 cycle and raise again -> run starts.
3. `Abort` pulse at cycle 16 of a run -> after that edge IDLE, `seconds_left`=0, `led`=0, `task_active`=1.
4. `Abort` on the same edge as the final tick (edge 22) -> IDLE, `done` never asserted.
5. `Abort` in DONE at edge 24 -> IDLE after edge 24. `Abort` pulsed in IDLE -> no output change.
6. `Reset` asserted at cycle 17 mid-run with `Start` still high -> all outputs at reset values after the edge. No new run until `Start` falls and rises.
